// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding word request, returned words buffered with PCs in a prefetch FIFO.
// Ack in cycle N is visible at the head in N+1; requests stop while the FIFO is full; redirect flushes.
module fetch_unit #(
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int unsigned       FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] pc_plus_four,
   input  logic              instr_ready
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] drop_addr_q;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       instr_mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] pc_mem_q [FIFO_DEPTH];

   logic              head_vld;
   logic              push;
   logic              pop;
   logic              room;
   logic              room_after;
   logic [ADDR_W-1:0] redirect_tgt;
   logic              unused_pc_lsbs;

   assign redirect_tgt   = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign unused_pc_lsbs = ^redirect_pc[1:0];
   assign head_vld       = (count_q != '0);
   assign push           = (state_q == REQ) && imem_ack && !redirect;
   assign pop            = head_vld && instr_ready && !redirect;
   assign room           = (count_q < CNT_W'(FIFO_DEPTH));
   assign room_after     = (count_d < CNT_W'(FIFO_DEPTH));

   // Redirect wins over push and pop: the whole FIFO is discarded.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= imem_rdata;
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      end
   end

   // DROP keeps the orphaned address on the bus while fetch_pc already holds the new target.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         fetch_pc_q  <= {RESET_PC[ADDR_W-1:2], 2'b00};
         drop_addr_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (redirect)  fetch_pc_q <= redirect_tgt;
               else if (room) state_q    <= REQ;
            end
            REQ: begin
               if (redirect) begin
                  fetch_pc_q  <= redirect_tgt;
                  drop_addr_q <= fetch_pc_q;
                  state_q     <= imem_ack ? IDLE : DROP;
               end else if (imem_ack) begin
                  fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
                  state_q    <= room_after ? REQ : IDLE;
               end
            end
            DROP: begin
               if (redirect) fetch_pc_q <= redirect_tgt;
               if (imem_ack) state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign imem_req     = (state_q == REQ) || (state_q == DROP);
   assign imem_addr    = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
   assign instr_valid  = head_vld;
   assign instr        = head_vld ? instr_mem_q[rd_ptr_q] : '0;
   assign instr_pc     = head_vld ? pc_mem_q[rd_ptr_q] : '0;
   assign pc_plus_four = head_vld ? pc_mem_q[rd_ptr_q] + ADDR_W'(4) : '0;

endmodule
